i2c_cmd_seq: RTL

- Command sequencer sitting directly upstream of the Wishbone I2C master (`wb_master`).
- Holds a host-loaded table of up to DEPTH I2C transactions and issues them one at a time on the master's i2c_* request interface:
  - drives operands, then a falling edge on i2c_wr;
  - tracks i2c_busy to completion;
  - captures read data into a result table the host reads back.
- Lets firmware or a top-level FSM poll a batch of sensors and registers with a single start pulse.

---
 rtl/i2c_seq_pkg.sv | 33 +++
 rtl/i2c_seq_table.sv | 41 ++++
 rtl/i2c_cmd_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C command sequencer: state encoding, command
// field offsets and per-direction byte-count limits.
package i2c_seq_pkg;

   typedef enum logic [8:0] {
      S_IDLE      = 9'b0_0000_0001,
      S_LOAD      = 9'b0_0000_0010,
      S_WR_HI     = 9'b0_0000_0100,
      S_WAIT_RISE = 9'b0_0000_1000,
      S_WAIT_FALL = 9'b0_0001_0000,
      S_CAPTURE   = 9'b0_0010_0000,
      S_NEXT      = 9'b0_0100_0000,
      S_GAP       = 9'b0_1000_0000,
      S_DONE      = 9'b1_0000_0000
   } state_e;

   localparam int unsigned CMD_W    = 40;
   localparam int unsigned RES_W    = 16;
   localparam int unsigned ADDR_LSB = 32;
   localparam int unsigned NUM_LSB  = 24;
   localparam int unsigned D1_LSB   = 16;
   localparam int unsigned D2_LSB   = 8;
   localparam int unsigned D3_LSB   = 0;

   localparam logic [7:0] MAX_WR_NUM = 8'd3;
   localparam logic [7:0] MAX_RD_NUM = 8'd2;

   // A command may launch only when its byte count fits the direction's range.
   function automatic logic num_legal(input logic [7:0] num, input logic is_rd);
      return (num != 8'd0) && (num <= (is_rd ? MAX_RD_NUM : MAX_WR_NUM));
   endfunction

endpackage

// File: rtl/i2c_seq_table.sv
// Command and result register arrays for the I2C sequencer, one write port
// and one combinational read port each; both cleared by reset.
module i2c_seq_table
   import i2c_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_we_i,
   input  logic [IDX_W-1:0] cmd_widx_i,
   input  logic [CMD_W-1:0] cmd_wdata_i,
   input  logic [IDX_W-1:0] cmd_ridx_i,
   output logic [CMD_W-1:0] cmd_rdata_o,
   input  logic             res_we_i,
   input  logic [IDX_W-1:0] res_widx_i,
   input  logic [RES_W-1:0] res_wdata_i,
   input  logic [IDX_W-1:0] res_ridx_i,
   output logic [RES_W-1:0] res_rdata_o
);

   logic [CMD_W-1:0] cmd_q [DEPTH];
   logic [RES_W-1:0] res_q [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            cmd_q[i] <= '0;
            res_q[i] <= '0;
         end
      end else begin
         if (cmd_we_i) cmd_q[cmd_widx_i] <= cmd_wdata_i;
         if (res_we_i) res_q[res_widx_i] <= res_wdata_i;
      end
   end

   assign cmd_rdata_o = cmd_q[cmd_ridx_i];
   assign res_rdata_o = res_q[res_ridx_i];

endmodule

// File: rtl/i2c_cmd_seq.sv
// Runs a host-loaded table of I2C transactions through the master's i2c_* port.
// Define I2C_CMD_SEQ_TIMEOUT_EN to bound the wait for i2c_busy to fall.
module i2c_cmd_seq
   import i2c_seq_pkg::*;
#(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned IDX_W       = 3,
   parameter int unsigned WR_HI_CYC   = 4,
   parameter int unsigned GAP_CYC     = 16,
   parameter int unsigned RISE_WAIT   = 8,
   parameter int unsigned TIMEOUT_CYC = 32'h000F_FFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [CMD_W-1:0] cfg_data,
   input  logic             seq_start,
   input  logic [IDX_W:0]   seq_len,
   output logic             seq_busy,
   output logic             seq_done,
   output logic             seq_err,
   output logic [IDX_W-1:0] err_idx,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [RES_W-1:0] rd_data,
   output logic             i2c_wr,
   output logic [7:0]       i2c_addr,
   output logic [7:0]       i2c_wrdata1,
   output logic [7:0]       i2c_wrdata2,
   output logic [7:0]       i2c_wrdata3,
   output logic [7:0]       i2c_data_num,
   input  logic             i2c_busy,
   input  logic [7:0]       i2c_rddata1,
   input  logic [7:0]       i2c_rddata2
);

   localparam int unsigned LEN_W   = IDX_W + 1;
   localparam int unsigned CNT_MAX = (GAP_CYC > WR_HI_CYC) ?
                                     ((GAP_CYC > RISE_WAIT) ? GAP_CYC : RISE_WAIT) :
                                     ((WR_HI_CYC > RISE_WAIT) ? WR_HI_CYC : RISE_WAIT);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   if ((1 << IDX_W) != DEPTH) begin : g_bad_idx_w
      $error("IDX_W must equal log2(DEPTH)");
   end
   if ((TIMEOUT_CYC == 0) || (TIMEOUT_CYC > 32'h000F_FFFF)) begin : g_bad_timeout
      $error("TIMEOUT_CYC must fit a 20-bit counter");
   end

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] err_idx_q, err_idx_d;
   logic             wr_q, wr_d;
   logic [7:0]       addr_q, addr_d, num_q, num_d;
   logic [7:0]       d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
   logic             err_c, res_we_c, launch_ok_c, tbl_we_c;
   logic [CMD_W-1:0] cmd_c;

`ifdef I2C_CMD_SEQ_TIMEOUT_EN
   logic [19:0] to_cnt_q, to_cnt_d;
   // A master left busy by a timed-out command must settle before the next launch.
   assign launch_ok_c = !i2c_busy;
`else
   assign launch_ok_c = 1'b1;
`endif

   assign tbl_we_c = cfg_we && (state_q == S_IDLE);

   i2c_seq_table #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_table (
      .clk         (clk),
      .rst         (rst),
      .cmd_we_i    (tbl_we_c),
      .cmd_widx_i  (cfg_idx),
      .cmd_wdata_i (cfg_data),
      .cmd_ridx_i  (idx_q),
      .cmd_rdata_o (cmd_c),
      .res_we_i    (res_we_c),
      .res_widx_i  (idx_q),
      .res_wdata_i ({i2c_rddata2, i2c_rddata1}),
      .res_ridx_i  (rd_idx),
      .res_rdata_o (rd_data)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      err_d     = err_q;
      err_idx_d = err_idx_q;
      wr_d      = 1'b0;
      addr_d    = addr_q;
      num_d     = num_q;
      d1_d      = d1_q;
      d2_d      = d2_q;
      d3_d      = d3_q;
      err_c     = 1'b0;
      res_we_c  = 1'b0;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
      to_cnt_d  = to_cnt_q;
`endif
      case (state_q)
         S_IDLE: if (seq_start) begin
            err_d = 1'b0;
            idx_d = '0;
            if (seq_len == '0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               len_d   = (seq_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : seq_len;
               state_d = S_LOAD;
            end
         end
         S_LOAD: if (launch_ok_c) begin
            addr_d = cmd_c[ADDR_LSB +: 8];
            num_d  = cmd_c[NUM_LSB +: 8];
            d1_d   = cmd_c[D1_LSB +: 8];
            d2_d   = cmd_c[D2_LSB +: 8];
            d3_d   = cmd_c[D3_LSB +: 8];
            if (num_legal(cmd_c[NUM_LSB +: 8], cmd_c[ADDR_LSB])) begin
               state_d = S_WR_HI;
               wr_d    = 1'b1;
               cnt_d   = '0;
            end else begin
               err_c   = 1'b1;
               state_d = S_NEXT;
            end
         end
         S_WR_HI: begin
            if (cnt_q == CNT_W'(WR_HI_CYC - 1)) begin
               state_d = S_WAIT_RISE;
               cnt_d   = '0;
            end else begin
               wr_d  = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_RISE: begin
            if (i2c_busy) begin
               state_d = S_WAIT_FALL;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end else if (cnt_q == CNT_W'(RISE_WAIT - 1)) begin
               err_c   = 1'b1;
               state_d = S_NEXT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_FALL: begin
            if (!i2c_busy) begin
               state_d = S_CAPTURE;
            end
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
            else if (to_cnt_q == 20'(TIMEOUT_CYC - 1)) begin
               err_c   = 1'b1;
               state_d = S_NEXT;
            end else begin
               to_cnt_d = to_cnt_q + 20'd1;
            end
`endif
         end
         S_CAPTURE: begin
            res_we_c = addr_q[0];
            state_d  = S_NEXT;
         end
         S_NEXT: begin
            if (({1'b0, idx_q} + LEN_W'(1)) == len_q) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               cnt_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == CNT_W'(GAP_CYC - 1)) state_d = S_LOAD;
            else                              cnt_d   = cnt_q + CNT_W'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Only the first failing entry of a run is recorded.
      if (err_c) begin
         err_d = 1'b1;
         if (!err_q) err_idx_d = idx_q;
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         num_q     <= '0;
         d1_q      <= '0;
         d2_q      <= '0;
         d3_q      <= '0;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
         to_cnt_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         num_q     <= num_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
         d3_q      <= d3_d;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
         to_cnt_q  <= to_cnt_d;
`endif
      end
   end

   assign seq_busy     = busy_q;
   assign seq_done     = done_q;
   assign seq_err      = err_q;
   assign err_idx      = err_idx_q;
   assign i2c_wr       = wr_q;
   assign i2c_addr     = addr_q;
   assign i2c_data_num = num_q;
   assign i2c_wrdata1  = d1_q;
   assign i2c_wrdata2  = d2_q;
   assign i2c_wrdata3  = d3_q;

endmodule
